ser_frame_demux: RTL and testbench

- Parametrised successor of the lab's serial one-channel-transfer FSM.
- Receives bit-serial frames on serIn, one bit per push-button strobe (clkPB) synchronised into the system clock domain.
- Each frame carries a start bit, a channel address and a payload length; the payload is then routed to one of 2**ADDR_W serial outputs.
- Sits between the board push-button/switch inputs and the LED/7-seg display logic; cnt_out drives the display.

---
 rtl/ser_frame_demux.sv | 187 ++++++++++++++++++
 tb/tb_ser_frame_demux.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ser_frame_demux.sv
// ser_frame_demux: bit-serial frame receiver and channel router.
// One bit arrives per push-button strobe. A frame is a start bit (0), an
// ADDR_W-bit channel address (MSB first), a CNT_W-bit payload length (MSB
// first) and then that many payload bits, which are presented one by one on
// the addressed channel's serOut/serOutValid pair.
module ser_frame_demux #(
   parameter int ADDR_W = 2,
   parameter int CNT_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clkPB,
   input  logic                     serIn,
   output logic [(2**ADDR_W)-1:0]   serOut,
   output logic [(2**ADDR_W)-1:0]   serOutValid,
   output logic [CNT_W-1:0]         cnt_out,
   output logic [ADDR_W-1:0]        ch_out,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int NCH    = 2**ADDR_W;
   localparam int FLD_MX = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
   localparam int BC_W   = $clog2(FLD_MX) + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Shift one bit into the LSB of an address-wide register (MSB-first field).
   function automatic logic [ADDR_W-1:0] shift_addr(input logic [ADDR_W-1:0] v,
                                                    input logic b);
      logic [ADDR_W-1:0] r;
      r    = v << 1;
      r[0] = b;
      return r;
   endfunction

   // Shift one bit into the LSB of a length-wide register (MSB-first field).
   function automatic logic [CNT_W-1:0] shift_len(input logic [CNT_W-1:0] v,
                                                  input logic b);
      logic [CNT_W-1:0] r;
      r    = v << 1;
      r[0] = b;
      return r;
   endfunction

   // Synchroniser and edge-detect state
   logic pb_s1_q, pb_s2_q, pb_prev_q;
   logic ser_s1_q, ser_s2_q;

   // FSM state and registered outputs
   state_t            state_q;
   logic [BC_W-1:0]   bit_cnt_q;
   logic [CNT_W-1:0]  len_q;
   logic [ADDR_W-1:0] ch_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [NCH-1:0]    ser_out_q;
   logic [NCH-1:0]    ser_valid_q;
   logic              busy_q;
   logic              frame_done_q;

   // Combinational helpers
   logic              tick_s;
   logic              bit_s;
   logic [ADDR_W-1:0] ch_d;
   logic [CNT_W-1:0]  len_d;
   logic              addr_last_s;
   logic              len_last_s;

   // Two-stage synchronisers for strobe and data; both share stage alignment
   // so the data sampled on a tick is the value present with the strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         pb_s1_q   <= 1'b0;
         pb_s2_q   <= 1'b0;
         pb_prev_q <= 1'b0;
         ser_s1_q  <= 1'b0;
         ser_s2_q  <= 1'b0;
      end else begin
         pb_s1_q   <= clkPB;
         pb_s2_q   <= pb_s1_q;
         pb_prev_q <= pb_s2_q;
         ser_s1_q  <= serIn;
         ser_s2_q  <= ser_s1_q;
      end
   end

   // Rising-edge tick of the synchronised strobe and next field values.
   always_comb begin
      tick_s      = pb_s2_q & ~pb_prev_q;
      bit_s       = ser_s2_q;
      ch_d        = shift_addr(ch_q, bit_s);
      len_d       = shift_len(len_q, bit_s);
      addr_last_s = (bit_cnt_q == BC_W'(ADDR_W - 1));
      len_last_s  = (bit_cnt_q == BC_W'(CNT_W - 1));
   end

   // Frame FSM with registered outputs; advances on tick, DONE lasts one clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         len_q        <= '0;
         ch_q         <= '0;
         cnt_q        <= '0;
         ser_out_q    <= '0;
         ser_valid_q  <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         ser_valid_q  <= '0;
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // Only a 0 is a start bit; idle 1s are ignored.
               if (tick_s && !bit_s) begin
                  state_q   <= S_ADDR;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            S_ADDR: begin
               if (tick_s) begin
                  ch_q <= ch_d;
                  if (addr_last_s) begin
                     state_q   <= S_LEN;
                     bit_cnt_q <= '0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BC_W'(1);
                  end
               end
            end
            S_LEN: begin
               if (tick_s) begin
                  len_q <= len_d;
                  if (len_last_s) begin
                     bit_cnt_q <= '0;
                     if (len_d != '0) begin
                        state_q <= S_DATA;
                        cnt_q   <= len_d;
                     end else begin
                        // Empty payload: finish the frame immediately.
                        state_q      <= S_DONE;
                        cnt_q        <= '0;
                        frame_done_q <= 1'b1;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BC_W'(1);
                  end
               end
            end
            S_DATA: begin
               if (tick_s) begin
                  ser_out_q[ch_q]   <= bit_s;
                  ser_valid_q[ch_q] <= 1'b1;
                  cnt_q             <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q      <= S_DONE;
                     frame_done_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign serOut      = ser_out_q;
   assign serOutValid = ser_valid_q;
   assign cnt_out     = cnt_q;
   assign ch_out      = ch_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ser_frame_demux.sv
// Scoreboard bench for ser_frame_demux: default instance (ADDR_W=2, CNT_W=4)
// plus a small instance (ADDR_W=1, CNT_W=3) for the maximum-length frame.
module tb_ser_frame_demux;

   logic clk = 1'b0;
   logic rst;
   logic pb1, sin1, pb2, sin2;

   logic [3:0] so1, sov1, cnt1;
   logic [1:0] ch1;
   logic       busy1, fd1;

   logic [1:0] so2, sov2;
   logic [2:0] cnt2;
   logic [0:0] ch2;
   logic       busy2, fd2;

   typedef struct packed {
      logic [3:0] v;
      logic [3:0] s;
      logic [3:0] c;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   d1[$];
   int   d2[$];
   logic [3:0] m1, m2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ser_frame_demux #(.ADDR_W(2), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .clkPB(pb1), .serIn(sin1),
      .serOut(so1), .serOutValid(sov1), .cnt_out(cnt1), .ch_out(ch1),
      .busy(busy1), .frame_done(fd1)
   );

   ser_frame_demux #(.ADDR_W(1), .CNT_W(3)) dut2 (
      .clk(clk), .rst(rst), .clkPB(pb2), .serIn(sin2),
      .serOut(so2), .serOutValid(sov2), .cnt_out(cnt2), .ch_out(ch2),
      .busy(busy2), .frame_done(fd2)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int g_busy(input int w);
      return (w != 0) ? 32'(busy2) : 32'(busy1);
   endfunction
   function automatic int g_ch(input int w);
      return (w != 0) ? 32'(ch2) : 32'(ch1);
   endfunction
   function automatic int g_cnt(input int w);
      return (w != 0) ? 32'(cnt2) : 32'(cnt1);
   endfunction

   // Scoreboard monitor for instance 1: payload pulses and frame ends.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (sov1 != 4'd0) begin
         if (q1.size() == 0) begin
            chk_eq("d1_unexp_valid", 32'(sov1), 32'd0);
         end else begin
            e = q1.pop_front();
            chk_eq("d1_valid", 32'(sov1), 32'(e.v));
            chk_eq("d1_serout", 32'(so1), 32'(e.s));
            chk_eq("d1_cnt", 32'(cnt1), 32'(e.c));
         end
      end
      if (fd1) begin
         if (d1.size() == 0) begin
            chk_eq("d1_unexp_done", 32'(fd1), 32'd0);
         end else begin
            chk_eq("d1_done_ch", 32'(ch1), 32'(d1.pop_front()));
            chk_eq("d1_done_cnt", 32'(cnt1), 32'd0);
            chk_eq("d1_done_busy", 32'(busy1), 32'd1);
         end
      end
   end

   // Scoreboard monitor for instance 2.
   always @(negedge clk) begin : mon2
      exp_t e;
      if (sov2 != 2'd0) begin
         if (q2.size() == 0) begin
            chk_eq("d2_unexp_valid", 32'(sov2), 32'd0);
         end else begin
            e = q2.pop_front();
            chk_eq("d2_valid", 32'(sov2), 32'(e.v));
            chk_eq("d2_serout", 32'(so2), 32'(e.s));
            chk_eq("d2_cnt", 32'(cnt2), 32'(e.c));
         end
      end
      if (fd2) begin
         if (d2.size() == 0) begin
            chk_eq("d2_unexp_done", 32'(fd2), 32'd0);
         end else begin
            chk_eq("d2_done_ch", 32'(ch2), 32'(d2.pop_front()));
            chk_eq("d2_done_cnt", 32'(cnt2), 32'd0);
         end
      end
   end

   task automatic send_bit(input int w, input logic b);
      @(negedge clk);
      if (w != 0) begin sin2 = b; pb2 = 1'b1; end
      else        begin sin1 = b; pb1 = 1'b1; end
      repeat (4) @(negedge clk);
      if (w != 0) pb2 = 1'b0;
      else        pb1 = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic push_done(input int w, input int ch);
      if (w != 0) d2.push_back(ch);
      else        d1.push_back(ch);
   endtask

   // Send a frame; nsend payload bits are sent (fewer than len for aborts).
   task automatic send_frame(input int w, input int ch, input int len,
                             input logic [15:0] d, input int nsend, input bit skip_start);
      int   aw = (w != 0) ? 1 : 2;
      int   cw = (w != 0) ? 3 : 4;
      exp_t e;
      if (!skip_start) send_bit(w, 1'b0);
      chk_eq("busy_start", g_busy(w), 1);
      for (int i = aw - 1; i >= 0; i--) send_bit(w, 1'((ch >> i) & 1));
      chk_eq("ch_after_addr", g_ch(w), ch);
      for (int i = cw - 1; i >= 0; i--) begin
         if (i == 0 && len == 0) push_done(w, ch);
         send_bit(w, 1'((len >> i) & 1));
      end
      if (len == 0) begin
         chk_eq("busy_zero_len", g_busy(w), 0);
         chk_eq("cnt_zero_len", g_cnt(w), 0);
         return;
      end
      chk_eq("cnt_after_len", g_cnt(w), len);
      for (int i = 0; i < nsend; i++) begin
         if (w != 0) begin
            m2[ch] = d[i];
            e.v = 4'(1 << ch); e.s = m2; e.c = 4'(len - i - 1);
            q2.push_back(e);
         end else begin
            m1[ch] = d[i];
            e.v = 4'(1 << ch); e.s = m1; e.c = 4'(len - i - 1);
            q1.push_back(e);
         end
         if (i == len - 1) push_done(w, ch);
         send_bit(w, d[i]);
         chk_eq("cnt_data", g_cnt(w), len - i - 1);
      end
      if (nsend == len) begin
         chk_eq("busy_end", g_busy(w), 0);
         chk_eq("cnt_end", g_cnt(w), 0);
         chk_eq("ch_end", g_ch(w), ch);
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk_eq({tag, "_serout"}, 32'(so1), 32'd0);
      chk_eq({tag, "_valid"}, 32'(sov1), 32'd0);
      chk_eq({tag, "_cnt"}, 32'(cnt1), 32'd0);
      chk_eq({tag, "_ch"}, 32'(ch1), 32'd0);
      chk_eq({tag, "_busy"}, 32'(busy1), 32'd0);
      chk_eq({tag, "_done"}, 32'(fd1), 32'd0);
      chk_eq({tag, "_busy2"}, 32'(busy2), 32'd0);
      chk_eq({tag, "_cnt2"}, 32'(cnt2), 32'd0);
   endtask

   initial begin
      rst = 1'b1; pb1 = 1'b0; sin1 = 1'b0; pb2 = 1'b0; sin2 = 1'b0;
      m1 = 4'd0; m2 = 4'd0;

      // 1. Reset with the strobe toggling, then quiet idle.
      repeat (3) begin
         @(negedge clk);
         pb1 = ~pb1; pb2 = ~pb2;
      end
      @(negedge clk);
      chk_cleared("reset");
      pb1 = 1'b0; pb2 = 1'b0; rst = 1'b0;
      repeat (10) @(negedge clk);
      chk_cleared("idle");

      // 2. Normal frame: ch 2, len 3, payload 1,0,1.
      send_frame(0, 2, 3, 16'b101, 3, 1'b0);

      // 3. Zero-length frame to ch 1.
      send_frame(0, 1, 0, 16'h0, 0, 1'b0);

      // 4. Idle ones are ignored; a long press is one tick.
      repeat (5) send_bit(0, 1'b1);
      chk_eq("idle_ones_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      sin1 = 1'b0; pb1 = 1'b1;
      repeat (50) @(negedge clk);
      pb1 = 1'b0;
      repeat (4) @(negedge clk);
      send_frame(0, 3, 1, 16'h1, 1, 1'b1);

      // 5. Reset mid-payload, then a clean frame to ch 3, len 2.
      send_frame(0, 1, 3, 16'b101, 1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m1 = 4'd0; m2 = 4'd0;
      chk_cleared("mid_rst");
      send_frame(0, 3, 2, 16'b10, 2, 1'b0);

      // 6. Maximum length on the small instance.
      send_frame(1, 1, 7, 16'b1011001, 7, 1'b0);

      repeat (10) @(negedge clk);
      chk_eq("q1_empty", 32'(q1.size()), 32'd0);
      chk_eq("q2_empty", 32'(q2.size()), 32'd0);
      chk_eq("d1_empty", 32'(d1.size()), 32'd0);
      chk_eq("d2_empty", 32'(d2.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
